// File: rtl/efuse_pkg.sv
// Shared eFuse definitions: read sequencer state encoding, default macro timing,
// and the address/bank-select width helpers also used by the read/write controller.
package efuse_pkg;

  localparam int EFUSE_BITS = 256;
  localparam int NR_DEF     = 64;
  localparam int QW_DEF     = 8;
  localparam int T_SU_DEF   = 2;
  localparam int T_RD_DEF   = 4;
  localparam int T_HD_DEF   = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Width of the bank select for an nr-bit read window (never narrower than 1).
  function automatic int bank_sel_w(input int nr);
    return (EFUSE_BITS / nr > 1) ? $clog2(EFUSE_BITS / nr) : 1;
  endfunction

  function automatic int word_addr_w(input int qw);
    return (EFUSE_BITS / qw > 1) ? $clog2(EFUSE_BITS / qw) : 1;
  endfunction

endpackage

// File: rtl/efuse_phase_timer.sv
// Loadable down-counter with a zero flag; times the macro setup/strobe/hold phases.
module efuse_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Parks at zero so an idle timer never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/efuse_rd_seq.sv
// eFuse macro read sequencer: walks NR/QW words of the selected bank and returns them packed.
// Define EFUSE_RD_DBL_SAMPLE_EN to strobe every word twice and flag disagreements on read_err.
//
// Handshake: read_start is a one-cycle request, accepted only when the FSM is idle and
// efuse_busy_read is low; read_done is a one-cycle pulse with read_data valid in that cycle.
module efuse_rd_seq
  import efuse_pkg::*;
#(
  parameter int NR   = NR_DEF,
  parameter int QW   = QW_DEF,
  parameter int T_SU = T_SU_DEF,
  parameter int T_RD = T_RD_DEF,
  parameter int T_HD = T_HD_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          read_start,
  input  logic [bank_sel_w(NR)-1:0]     efuse_read_sel,
  output logic                          read_done,
  output logic [NR-1:0]                 read_data,
  output logic                          efuse_busy_read,
`ifdef EFUSE_RD_DBL_SAMPLE_EN
  output logic                          read_err,
`endif
  output logic                          efuse_csb,
  output logic                          efuse_load,
  output logic                          efuse_pgenb,
  output logic                          efuse_strobe,
  output logic [word_addr_w(QW)-1:0]    efuse_addr,
  input  logic [QW-1:0]                 efuse_q,
  output state_t                        dbg_state
);

  localparam int NWD    = NR / QW;
  localparam int SEL_W  = bank_sel_w(NR);
  localparam int ADDR_W = word_addr_w(QW);
  localparam int WC_W   = (NWD > 1) ? $clog2(NWD) : 1;
  localparam int T_MAX  = (T_SU > T_RD) ? ((T_SU > T_HD) ? T_SU : T_HD)
                                        : ((T_RD > T_HD) ? T_RD : T_HD);
  localparam int TW     = $clog2(T_MAX + 1);

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic [WC_W-1:0]    word_cnt;
  logic [NR-1:0]      rd_buf;
  logic               accept;
  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_zero;
`ifdef EFUSE_RD_DBL_SAMPLE_EN
  logic               pass_q;
  logic               err_acc;
`endif

  function automatic logic [ADDR_W-1:0] addr_of(input logic [SEL_W-1:0] s,
                                                input logic [WC_W-1:0]  w);
    return ADDR_W'(s) * ADDR_W'(NWD) + ADDR_W'(w);
  endfunction

  // Busy still covers the read_done cycle, so gating on it also rejects a start there.
  assign accept    = (state == IDLE) && read_start && !efuse_busy_read;
  assign dbg_state = state;

  // Each timer load happens on the edge that enters the phase it times.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(T_SU - 1);
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(T_RD - 1);
        end
      end
      STROBE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(T_HD - 1);
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(T_SU - 1);
`ifdef EFUSE_RD_DBL_SAMPLE_EN
          if (!pass_q) tmr_val = TW'(T_RD - 1);
`endif
        end
      end
      default: ;
    endcase
  end

  efuse_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      sel_q           <= '0;
      word_cnt        <= '0;
      rd_buf          <= '0;
      read_data       <= '0;
      read_done       <= 1'b0;
      efuse_busy_read <= 1'b0;
      efuse_csb       <= 1'b1;
      efuse_load      <= 1'b0;
      efuse_pgenb     <= 1'b1;
      efuse_strobe    <= 1'b0;
      efuse_addr      <= '0;
`ifdef EFUSE_RD_DBL_SAMPLE_EN
      pass_q          <= 1'b0;
      err_acc         <= 1'b0;
      read_err        <= 1'b0;
`endif
    end else begin
      efuse_pgenb <= 1'b1;
      case (state)
        IDLE: begin
          read_done <= 1'b0;
          if (accept) begin
            sel_q           <= efuse_read_sel;
            word_cnt        <= '0;
            efuse_busy_read <= 1'b1;
            efuse_csb       <= 1'b0;
            efuse_load      <= 1'b1;
            efuse_addr      <= addr_of(efuse_read_sel, '0);
            state           <= SETUP;
`ifdef EFUSE_RD_DBL_SAMPLE_EN
            pass_q          <= 1'b0;
            err_acc         <= 1'b0;
`endif
          end else begin
            efuse_busy_read <= 1'b0;
          end
        end
        SETUP: begin
          if (tmr_zero) begin
            efuse_strobe <= 1'b1;
            state        <= STROBE;
          end
        end
        STROBE: begin
          if (tmr_zero) begin
            efuse_strobe <= 1'b0;
            state        <= HOLD;
`ifdef EFUSE_RD_DBL_SAMPLE_EN
            if (pass_q) begin
              if (efuse_q != rd_buf[int'(word_cnt)*QW +: QW]) err_acc <= 1'b1;
            end else begin
              rd_buf[int'(word_cnt)*QW +: QW] <= efuse_q;
            end
`else
            rd_buf[int'(word_cnt)*QW +: QW] <= efuse_q;
`endif
          end
        end
        HOLD: begin
          if (tmr_zero) begin
`ifdef EFUSE_RD_DBL_SAMPLE_EN
            if (!pass_q) begin
              pass_q       <= 1'b1;
              efuse_strobe <= 1'b1;
              state        <= STROBE;
            end else
`endif
            if (word_cnt == WC_W'(NWD - 1)) begin
              efuse_csb  <= 1'b1;
              efuse_load <= 1'b0;
              state      <= DONE;
            end else begin
              word_cnt   <= word_cnt + 1'b1;
              efuse_addr <= addr_of(sel_q, word_cnt + 1'b1);
              state      <= SETUP;
`ifdef EFUSE_RD_DBL_SAMPLE_EN
              pass_q     <= 1'b0;
`endif
            end
          end
        end
        DONE: begin
          read_data <= rd_buf;
          read_done <= 1'b1;
`ifdef EFUSE_RD_DBL_SAMPLE_EN
          read_err  <= err_acc;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_rd_seq.sv
// Self-checking bench for efuse_rd_seq against a behavioural fuse-array model.
module tb_efuse_rd_seq;
  import efuse_pkg::*;

  localparam int NR   = 64;
  localparam int QW   = 8;
  localparam int T_SU = 2;
  localparam int T_RD = 4;
  localparam int T_HD = 2;
  localparam int NWD  = NR / QW;
`ifdef EFUSE_RD_DBL_SAMPLE_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int LAT = NWD * (T_SU + PASSES * (T_RD + T_HD)) + 1;

  logic          clk;
  logic          rst;
  logic          read_start;
  logic [1:0]    efuse_read_sel;
  logic          read_done;
  logic [NR-1:0] read_data;
  logic          efuse_busy_read;
  logic          efuse_csb;
  logic          efuse_load;
  logic          efuse_pgenb;
  logic          efuse_strobe;
  logic [4:0]    efuse_addr;
  logic [QW-1:0] efuse_q;
  state_t        dbg_state;
`ifdef EFUSE_RD_DBL_SAMPLE_EN
  logic          read_err;
`endif

  efuse_rd_seq #(.NR(NR), .QW(QW), .T_SU(T_SU), .T_RD(T_RD), .T_HD(T_HD)) dut (
    .clk             (clk),
    .rst             (rst),
    .read_start      (read_start),
    .efuse_read_sel  (efuse_read_sel),
    .read_done       (read_done),
    .read_data       (read_data),
    .efuse_busy_read (efuse_busy_read),
`ifdef EFUSE_RD_DBL_SAMPLE_EN
    .read_err        (read_err),
`endif
    .efuse_csb       (efuse_csb),
    .efuse_load      (efuse_load),
    .efuse_pgenb     (efuse_pgenb),
    .efuse_strobe    (efuse_strobe),
    .efuse_addr      (efuse_addr),
    .efuse_q         (efuse_q),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  // fuse array model; flip_en corrupts bit 5 of the second strobe of word 2
  logic [7:0] fuse_mem [32];
  int         rise_cnt;
  bit         flip_en;

  always_comb begin
    efuse_q = 8'h00;
    if (efuse_strobe)
      efuse_q = fuse_mem[efuse_addr] ^ ((flip_en && rise_cnt == 6) ? 8'h20 : 8'h00);
  end

  // scoreboard
  logic [NR-1:0] exp_q[$];
  logic [NR-1:0] exp_v;
  logic [NR-1:0] last_exp;
  int checks;
  int failures;

  // per-read observations gathered by run_read
  int            done_at, done_cnt, busy_cyc, csb_low_cyc, pgenb_low, first_strobe_at;
  bit            timed_out;
  logic [NR-1:0] rd_at_done, rd_pre_done;
  logic          err_at_done;
  logic [4:0]    strobe_addrs[$];
  int            strobe_lens[$];

  function automatic logic [NR-1:0] exp_data(input int sel);
    logic [NR-1:0] r;
    r = '0;
    for (int w = 0; w < NWD; w++) r[w*QW +: QW] = fuse_mem[sel*NWD + w];
    return r;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) fuse_mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Driver + monitor: issues one read, optionally re-pulses read_start at given
  // cycles (relative to the accept edge), and returns once busy has dropped.
  task automatic run_read(input logic [1:0] sel, input int poke_a, input int poke_b,
                          input int poke_c);
    int   cyc;
    int   run;
    logic prev_strobe;
    done_at = -1; done_cnt = 0; busy_cyc = 0; csb_low_cyc = 0; pgenb_low = 0;
    first_strobe_at = -1; timed_out = 0; rd_at_done = '0; rd_pre_done = '0;
    err_at_done = 1'b0;
    strobe_addrs.delete();
    strobe_lens.delete();
    rise_cnt = 0;
    efuse_read_sel = sel;
    read_start = 1'b1;
    exp_q.push_back(exp_data(sel));
    @(posedge clk); #1;
    read_start = 1'b0;
    cyc = 0; run = 0; prev_strobe = 1'b0;
    while (1) begin
      if (efuse_busy_read) busy_cyc++;
      if (!efuse_csb) csb_low_cyc++;
      if (!efuse_pgenb) pgenb_low++;
      if (efuse_strobe && !prev_strobe) begin
        rise_cnt++;
        strobe_addrs.push_back(efuse_addr);
        if (first_strobe_at < 0) first_strobe_at = cyc;
        run = 0;
      end
      if (efuse_strobe) run++;
      if (!efuse_strobe && prev_strobe) strobe_lens.push_back(run);
      prev_strobe = efuse_strobe;
      if (cyc == LAT - 1) rd_pre_done = read_data;
      if (read_done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at    = cyc;
          rd_at_done = read_data;
`ifdef EFUSE_RD_DBL_SAMPLE_EN
          err_at_done = read_err;
`endif
        end
      end
      read_start = (cyc == poke_a) || (cyc == poke_b) || (cyc == poke_c);
      if (!efuse_busy_read) break;
      if (cyc >= LAT + 20) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    read_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (read_done !== 1'b0) begin failures++; $display("FAIL reset_read_done: got %b expected 0", read_done); end
    checks++; if (read_data !== '0) begin failures++; $display("FAIL reset_read_data: got %h expected 0", read_data); end
    checks++; if (efuse_busy_read !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", efuse_busy_read); end
    checks++; if (efuse_csb !== 1'b1) begin failures++; $display("FAIL reset_csb: got %b expected 1", efuse_csb); end
    checks++; if (efuse_load !== 1'b0) begin failures++; $display("FAIL reset_load: got %b expected 0", efuse_load); end
    checks++; if (efuse_pgenb !== 1'b1) begin failures++; $display("FAIL reset_pgenb: got %b expected 1", efuse_pgenb); end
    checks++; if (efuse_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b expected 0", efuse_strobe); end
    checks++; if (efuse_addr !== 5'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", efuse_addr); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
`ifdef EFUSE_RD_DBL_SAMPLE_EN
    checks++; if (read_err !== 1'b0) begin failures++; $display("FAIL reset_read_err: got %b expected 0", read_err); end
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (efuse_busy_read !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", efuse_busy_read); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < NWD; i++) fuse_mem[i] = 8'(i + 1);
    run_read(2'd0, -1, -1, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout: got busy stuck expected busy to fall"); end
    checks++; if (done_at !== LAT) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", done_at, LAT); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy_cyc !== LAT + 1) begin failures++; $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cyc, LAT + 1); end
    checks++; if (rd_at_done !== 64'h0807060504030201) begin failures++; $display("FAIL basic_data_const: got %h expected 0807060504030201", rd_at_done); end
    exp_v = exp_q.pop_front();
    checks++; if (rd_at_done !== exp_v) begin failures++; $display("FAIL basic_data: got %h expected %h", rd_at_done, exp_v); end
`ifdef EFUSE_RD_DBL_SAMPLE_EN
    checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL basic_read_err: got %b expected 0", err_at_done); end
`endif
    last_exp = exp_v;
  endtask

  task automatic test_addr_timing();
    run_read(2'd3, -1, -1, -1);
    checks++; if (first_strobe_at !== T_SU) begin failures++; $display("FAIL setup_cycles: got %0d expected %0d", first_strobe_at, T_SU); end
    checks++; if (strobe_addrs.size() !== NWD * PASSES) begin failures++; $display("FAIL strobe_count: got %0d expected %0d", strobe_addrs.size(), NWD * PASSES); end
    for (int k = 0; k < strobe_addrs.size(); k++) begin
      checks++;
      if (strobe_addrs[k] !== 5'(3 * NWD + k / PASSES)) begin
        failures++; $display("FAIL strobe_addr[%0d]: got %0d expected %0d", k, strobe_addrs[k], 3 * NWD + k / PASSES);
      end
    end
    for (int k = 0; k < strobe_lens.size(); k++) begin
      checks++;
      if (strobe_lens[k] !== T_RD) begin failures++; $display("FAIL strobe_len[%0d]: got %0d expected %0d", k, strobe_lens[k], T_RD); end
    end
    checks++; if (csb_low_cyc !== LAT - 1) begin failures++; $display("FAIL csb_low_cycles: got %0d expected %0d", csb_low_cyc, LAT - 1); end
    checks++; if (pgenb_low !== 0) begin failures++; $display("FAIL pgenb_low_cycles: got %0d expected 0", pgenb_low); end
    exp_v = exp_q.pop_front();
    checks++; if (rd_at_done !== exp_v) begin failures++; $display("FAIL bank3_data: got %h expected %h", rd_at_done, exp_v); end
    last_exp = exp_v;
  endtask

  task automatic test_ignore();
    run_read(2'd1, 10, LAT - 1, LAT);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_at !== LAT) begin failures++; $display("FAIL ignore_latency: got %0d expected %0d", done_at, LAT); end
    checks++; if (rd_pre_done !== last_exp) begin failures++; $display("FAIL ignore_data_held: got %h expected %h", rd_pre_done, last_exp); end
    exp_v = exp_q.pop_front();
    checks++; if (rd_at_done !== exp_v) begin failures++; $display("FAIL ignore_data: got %h expected %h", rd_at_done, exp_v); end
    last_exp = exp_v;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (efuse_busy_read !== 1'b0) begin failures++; $display("FAIL ignore_no_queue: got busy %b expected 0", efuse_busy_read); end
    checks++; if (read_data !== last_exp) begin failures++; $display("FAIL ignore_data_stable: got %h expected %h", read_data, last_exp); end
  endtask

  task automatic test_abort();
    int dones;
    dones = 0;
    efuse_read_sel = 2'd2;
    read_start = 1'b1;
    @(posedge clk); #1;
    read_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (read_done) dones++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++; if (efuse_csb !== 1'b1) begin failures++; $display("FAIL abort_csb: got %b expected 1", efuse_csb); end
    checks++; if (efuse_strobe !== 1'b0) begin failures++; $display("FAIL abort_strobe: got %b expected 0", efuse_strobe); end
    checks++; if (efuse_busy_read !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", efuse_busy_read); end
    checks++; if (read_data !== '0) begin failures++; $display("FAIL abort_read_data: got %h expected 0", read_data); end
    checks++; if (efuse_load !== 1'b0) begin failures++; $display("FAIL abort_load: got %b expected 0", efuse_load); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, IDLE); end
    for (int c = 0; c < LAT + 10; c++) begin
      if (read_done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
    run_read(2'd2, -1, -1, -1);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL post_abort_done_count: got %0d expected 1", done_cnt); end
    exp_v = exp_q.pop_front();
    checks++; if (rd_at_done !== exp_v) begin failures++; $display("FAIL post_abort_data: got %h expected %h", rd_at_done, exp_v); end
    last_exp = exp_v;
  endtask

  task automatic test_back_to_back();
    fill_mem();
    run_read(2'd0, -1, -1, -1);
    exp_v = exp_q.pop_front();
    checks++; if (rd_at_done !== exp_v) begin failures++; $display("FAIL b2b_first_data: got %h expected %h", rd_at_done, exp_v); end
    run_read(2'd1, -1, -1, -1);
    checks++; if (done_at !== LAT) begin failures++; $display("FAIL b2b_second_latency: got %0d expected %0d", done_at, LAT); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL b2b_second_done_count: got %0d expected 1", done_cnt); end
    exp_v = exp_q.pop_front();
    checks++; if (read_data !== exp_v) begin failures++; $display("FAIL b2b_second_data: got %h expected %h", read_data, exp_v); end
    last_exp = exp_v;
  endtask

`ifdef EFUSE_RD_DBL_SAMPLE_EN
  task automatic test_dbl_sample();
    flip_en = 1'b1;
    run_read(2'd2, -1, -1, -1);
    flip_en = 1'b0;
    checks++; if (err_at_done !== 1'b1) begin failures++; $display("FAIL dbl_err_flag: got %b expected 1", err_at_done); end
    exp_v = exp_q.pop_front();
    checks++; if (rd_at_done !== exp_v) begin failures++; $display("FAIL dbl_first_sample: got %h expected %h", rd_at_done, exp_v); end
    run_read(2'd2, -1, -1, -1);
    checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL dbl_stable_err: got %b expected 0", err_at_done); end
    checks++; if (done_at !== 113) begin failures++; $display("FAIL dbl_latency: got %0d expected 113", done_at); end
    exp_v = exp_q.pop_front();
    checks++; if (rd_at_done !== exp_v) begin failures++; $display("FAIL dbl_stable_data: got %h expected %h", rd_at_done, exp_v); end
  endtask
`endif

  initial begin
    rst            = 1'b1;
    read_start     = 1'b0;
    efuse_read_sel = 2'd0;
    flip_en        = 1'b0;
    rise_cnt       = 0;
    checks         = 0;
    failures       = 0;
    last_exp       = '0;
    fill_mem();
    test_reset();
    test_basic();
    test_addr_timing();
    test_ignore();
    test_abort();
    test_back_to_back();
`ifdef EFUSE_RD_DBL_SAMPLE_EN
    test_dbl_sample();
`endif
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
